mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory access sequencer directly downstream of the counter/address registers (PC, SP, transfer pointers).
- Consumes the 16-bit address those registers assert onto the address bus.
- Runs one read or write cycle against external memory, with wait states and a timeout.
- Returns an optional post-increment/decrement strobe to the source register, which gives auto-increment addressing.

Parameters:
ADDR_WIDTH, 16, width of address bus.
DATA_WIDTH, 8, width of memory data path.
TIMEOUT, 15, max STROBE cycles without mem_ready before abort (1..255).

Ports:
clock  in  1  system clock; all logic on rising edge
clear  in  1  synchronous reset, active-high
addr_in  in  ADDR_WIDTH  address from counter/address register Addr output
req_rd  in  1  read request, sampled in IDLE
req_wr  in  1  write request, sampled in IDLE
wr_data  in  DATA_WIDTH  write data, captured on accept
post_inc  in  1  request inc strobe after successful access, captured on accept
post_dec  in  1  request dec strobe after successful access, captured on accept
req_ready  out  1  high in IDLE (request will be accepted)
mem_addr  out  ADDR_WIDTH  registered address to memory
mem_wdata  out  DATA_WIDTH  registered write data
mem_rd_n  out  1  read strobe, active low
mem_wr_n  out  1  write strobe, active low
mem_rdata  in  DATA_WIDTH  memory read data
mem_ready  in  1  memory completes access this cycle
rd_data  out  DATA_WIDTH  last successfully read byte, held until next successful read
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse in HOLD
err  out  1  one-cycle pulse with done on timeout, or one-cycle pulse on rejected request
inc_n  out  1  active-low one-cycle strobe to counter register inc (rising edge on release counts)
dec_n  out  1  active-low one-cycle strobe to counter register dec

Behaviour:
- Reset values while clear=1:
  - mem_addr=0, mem_wdata=0, rd_data=0.
  - mem_rd_n=1, mem_wr_n=1, inc_n=1, dec_n=1.
  - busy=0, done=0, err=0, state=IDLE, wait counter=0.
- clear overrides everything, including mid-access: strobes return high on the same edge and no done/inc/dec is issued.
- All outputs are registered; no combinational path from inputs to outputs, except req_ready = (state==IDLE).
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - Exactly one of req_rd/req_wr high: capture addr_in into mem_addr, wr_data into mem_wdata, and latch op, post_inc, post_dec; go to SETUP.
  - req_rd and req_wr both high: err pulses next cycle, no access, stay IDLE.
- SETUP (1 cycle): address stable, strobes high (address setup time).
- STROBE:
  - Drive mem_rd_n=0 (read) or mem_wr_n=0 (write); wait counter starts at 0.
  - mem_ready=1 sampled: on read, register mem_rdata into rd_data; go to HOLD with success.
  - Else: counter+1. When counter reaches TIMEOUT without ready, go to HOLD with failure. rd_data is not updated.
- HOLD (1 cycle):
  - Strobes high, mem_addr and mem_wdata held, done=1.
  - err=1 on failure.
  - On success: post_inc alone -> inc_n=0; post_dec alone -> dec_n=0; both set -> neither strobe, no error.
  - No strobe on failure.
  - Next state IDLE.
- Latency with zero wait states:
  - Accept edge = cycle 0; strobe low cycle 1..1 after SETUP.
  - Concretely: SETUP cycle 1, STROBE cycle 2, HOLD/done cycle 3, req_ready again cycle 4.
  - Each wait state adds 1 cycle.
  - Back-to-back throughput: 1 access per 4 cycles.
- Requests while busy=1 are ignored (not queued); the source must hold its request until req_ready.
- addr_in changes after accept have no effect on the access in flight.
- Wait counter is 8 bits and saturates; no wrap-around.
- mem_ready outside STROBE is ignored.

Test Plan:
- clear=1 for 2 cycles with req_rd=1, addr_in=16'hAAAA -> all outputs at reset values, mem_rd_n stays 1, busy=0.
- Read addr_in=16'h1234, mem_ready=1 in first STROBE cycle, mem_rdata=8'h5A, post_inc=1 -> mem_rd_n low exactly 1 cycle, done and inc_n=0 in cycle 3, rd_data=8'h5A, busy low in cycle 4.
- Write addr_in=16'hAAA8, wr_data=8'hC3, mem_ready delayed 3 cycles, post_dec=1 -> mem_wr_n low 4 cycles, mem_wdata=8'hC3 throughout, dec_n=0 with done, rd_data unchanged.
- Read with mem_ready held 0, TIMEOUT=15 -> mem_rd_n low 15 cycles, then done=1 and err=1 together, no inc_n/dec_n, rd_data keeps previous 8'h5A.
- req_rd=req_wr=1 in IDLE -> single err pulse, no strobes, busy=0. req_rd pulsed while busy -> ignored, only one done.
- clear asserted during STROBE of a write -> mem_wr_n=1 next edge, no done, state IDLE. A following read of 16'h0001 completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory access sequencer: one read or write per request, with wait states, timeout and post inc/dec strobe.
// Sequence is IDLE -> SETUP -> STROBE (mem_ready or timeout) -> HOLD, then back to IDLE; requests are ignored while busy.
module mem_access_stage #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  post_inc,
  input  logic                  post_dec,
  output logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd_n,
  output logic                  mem_wr_n,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  inc_n,
  output logic                  dec_n
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t                state_q, state_d;
  logic [7:0]            wait_q, wait_d;
  logic                  op_wr_q, op_wr_d;
  logic                  post_inc_q, post_inc_d;
  logic                  post_dec_q, post_dec_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  mem_rd_n_q, mem_rd_n_d;
  logic                  mem_wr_n_q, mem_wr_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  inc_n_q, inc_n_d;
  logic                  dec_n_q, dec_n_d;
  logic [7:0]            wait_inc;
  logic                  to_hold;
  logic                  success;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    op_wr_d     = op_wr_q;
    post_inc_d  = post_inc_q;
    post_dec_d  = post_dec_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    mem_rd_n_d  = mem_rd_n_q;
    mem_wr_n_d  = mem_wr_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    inc_n_d     = 1'b1;
    dec_n_d     = 1'b1;
    to_hold     = 1'b0;
    success     = 1'b0;
    wait_inc    = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (req_rd ^ req_wr) begin
          mem_addr_d  = addr_in;
          mem_wdata_d = wr_data;
          op_wr_d     = req_wr;
          post_inc_d  = post_inc;
          post_dec_d  = post_dec;
          busy_d      = 1'b1;
          state_d     = SETUP;
        end else if (req_rd && req_wr) begin
          err_d = 1'b1;
        end
      end
      SETUP: begin
        wait_d     = 8'd0;
        mem_rd_n_d = op_wr_q;
        mem_wr_n_d = !op_wr_q;
        state_d    = STROBE;
      end
      STROBE: begin
        if (mem_ready) begin
          if (!op_wr_q) rd_data_d = mem_rdata;
          to_hold = 1'b1;
          success = 1'b1;
        end else begin
          wait_d = wait_inc;
          if (wait_inc >= TIMEOUT_CNT) to_hold = 1'b1;
        end
      end
      HOLD: begin
        wait_d  = 8'd0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Both post flags set on the same access cancel each other out.
    if (to_hold) begin
      state_d    = HOLD;
      mem_rd_n_d = 1'b1;
      mem_wr_n_d = 1'b1;
      done_d     = 1'b1;
      err_d      = !success;
      inc_n_d    = !(success && post_inc_q && !post_dec_q);
      dec_n_d    = !(success && post_dec_q && !post_inc_q);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      wait_q      <= 8'd0;
      op_wr_q     <= 1'b0;
      post_inc_q  <= 1'b0;
      post_dec_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      mem_rd_n_q  <= 1'b1;
      mem_wr_n_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      inc_n_q     <= 1'b1;
      dec_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      op_wr_q     <= op_wr_d;
      post_inc_q  <= post_inc_d;
      post_dec_q  <= post_dec_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      mem_rd_n_q  <= mem_rd_n_d;
      mem_wr_n_q  <= mem_wr_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      inc_n_q     <= inc_n_d;
      dec_n_q     <= dec_n_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_data   = rd_data_q;
  assign mem_rd_n  = mem_rd_n_q;
  assign mem_wr_n  = mem_wr_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign inc_n     = inc_n_q;
  assign dec_n     = dec_n_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random accesses against a per-access outcome model.
module tb_mem_access_stage;
  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] addr_in;
  logic        req_rd, req_wr;
  logic [7:0]  wr_data;
  logic        post_inc, post_dec;
  logic        req_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd_n, mem_wr_n;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [7:0]  rd_data;
  logic        busy, done, err, inc_n, dec_n;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rd = 8'h00;

  always #5 clock = ~clock;

  mem_access_stage #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(TO)) dut (
    .clock(clock), .clear(clear), .addr_in(addr_in), .req_rd(req_rd), .req_wr(req_wr),
    .wr_data(wr_data), .post_inc(post_inc), .post_dec(post_dec), .req_ready(req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .rd_data(rd_data), .busy(busy),
    .done(done), .err(err), .inc_n(inc_n), .dec_n(dec_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"},  32'(mem_addr), 32'h0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, "_rdata"}, 32'(rd_data), 32'h0);
    check({tag, "_rd_n"},  32'(mem_rd_n), 32'h1);
    check({tag, "_wr_n"},  32'(mem_wr_n), 32'h1);
    check({tag, "_inc_n"}, 32'(inc_n), 32'h1);
    check({tag, "_dec_n"}, 32'(dec_n), 32'h1);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_done"},  32'(done), 32'h0);
    check({tag, "_err"},   32'(err), 32'h0);
    check({tag, "_ready"}, 32'(req_ready), 32'h1);
  endtask

  // One complete access from IDLE back to IDLE; the expected outcome follows from the
  // delay alone: ready after 'delay' wait states, or abort after TO strobe cycles.
  task automatic run_access(input string tag, input bit is_wr, input logic [15:0] a,
                            input logic [7:0] wd, input bit pi, input bit pd,
                            input int delay, input logic [7:0] rdat, input bit poke_busy);
    bit fail;
    int strobe_len, rd_low, wr_low, done_cnt, done_cyc, err_at_done, err_other;
    int inc_cnt, inc_cyc, dec_cnt, dec_cyc, addr_bad, wdata_bad, idle_cyc;
    bit exp_inc, exp_dec;
    fail       = (delay >= TO);
    strobe_len = fail ? TO : delay + 1;
    exp_inc    = !fail && pi && !pd;
    exp_dec    = !fail && pd && !pi;
    rd_low = 0; wr_low = 0; done_cnt = 0; done_cyc = -1; err_at_done = 0; err_other = 0;
    inc_cnt = 0; inc_cyc = -1; dec_cnt = 0; dec_cyc = -1; addr_bad = 0; wdata_bad = 0;
    idle_cyc = -1;

    check({tag, "_ready_in"}, 32'(req_ready), 32'h1);
    req_rd = !is_wr; req_wr = is_wr; addr_in = a; wr_data = wd; post_inc = pi; post_dec = pd;
    tick();
    req_rd = 1'b0; req_wr = 1'b0;
    addr_in = 16'($urandom); wr_data = 8'($urandom);
    post_inc = 1'($urandom); post_dec = 1'($urandom);

    for (int cyc = 1; cyc < 400 && idle_cyc < 0; cyc++) begin
      if (!busy) begin
        idle_cyc = cyc;
      end else begin
        if (!mem_rd_n) rd_low++;
        if (!mem_wr_n) wr_low++;
        if (done) begin done_cnt++; done_cyc = cyc; err_at_done = int'(err); end
        else if (err) err_other++;
        if (!inc_n) begin inc_cnt++; inc_cyc = cyc; end
        if (!dec_n) begin dec_cnt++; dec_cyc = cyc; end
        if (mem_addr !== a) addr_bad++;
        if (is_wr && mem_wdata !== wd) wdata_bad++;
        mem_ready = (cyc == 1) ? 1'($urandom) : (cyc == 2 + delay);
        mem_rdata = (cyc == 2 + delay) ? rdat : 8'($urandom);
        req_rd    = poke_busy && (cyc == 2);
        tick();
      end
    end
    mem_ready = 1'b0;
    req_rd    = 1'b0;

    if (!is_wr && !fail) exp_rd = rdat;
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(2 + strobe_len));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_idle_cyc"}, 32'(idle_cyc), 32'(3 + strobe_len));
    check({tag, "_rd_low"},   32'(rd_low), is_wr ? 32'd0 : 32'(strobe_len));
    check({tag, "_wr_low"},   32'(wr_low), is_wr ? 32'(strobe_len) : 32'd0);
    check({tag, "_err_done"}, 32'(err_at_done), 32'(fail));
    check({tag, "_err_other"}, 32'(err_other), 32'd0);
    check({tag, "_inc_cnt"},  32'(inc_cnt), 32'(exp_inc));
    check({tag, "_dec_cnt"},  32'(dec_cnt), 32'(exp_dec));
    if (exp_inc) check({tag, "_inc_cyc"}, 32'(inc_cyc), 32'(done_cyc));
    if (exp_dec) check({tag, "_dec_cyc"}, 32'(dec_cyc), 32'(done_cyc));
    check({tag, "_addr_stable"}, 32'(addr_bad), 32'd0);
    check({tag, "_wdata_stable"}, 32'(wdata_bad), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'(exp_rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; req_rd = 1'b1; req_wr = 1'b0; addr_in = 16'hAAAA; wr_data = 8'h00;
    post_inc = 1'b0; post_dec = 1'b0; mem_rdata = 8'h00; mem_ready = 1'b0;
    tick();
    check_reset_state("rst1");
    tick();
    check_reset_state("rst2");
    clear = 1'b0; req_rd = 1'b0;
    tick();
    check_reset_state("post_rst");

    run_access("rd_inc",   1'b0, 16'h1234, 8'h00, 1'b1, 1'b0, 0,  8'h5A, 1'b0);
    run_access("wr_dec",   1'b1, 16'hAAA8, 8'hC3, 1'b0, 1'b1, 3,  8'h00, 1'b0);
    check("wr_wdata_after", 32'(mem_wdata), 32'hC3);
    run_access("rd_tmo",   1'b0, 16'h4321, 8'h00, 1'b1, 1'b0, 40, 8'hEE, 1'b0);
    check("tmo_keeps_rd", 32'(rd_data), 32'h5A);
    run_access("rd_edge",  1'b0, 16'h0100, 8'h00, 1'b1, 1'b0, TO - 1, 8'h77, 1'b0);
    run_access("rd_tmo_edge", 1'b0, 16'h0101, 8'h00, 1'b0, 1'b1, TO, 8'h66, 1'b0);

    req_rd = 1'b1; req_wr = 1'b1; addr_in = 16'hBEEF;
    tick();
    req_rd = 1'b0; req_wr = 1'b0;
    check("rej_err",   32'(err), 32'h1);
    check("rej_busy",  32'(busy), 32'h0);
    check("rej_rd_n",  32'(mem_rd_n), 32'h1);
    check("rej_wr_n",  32'(mem_wr_n), 32'h1);
    check("rej_done",  32'(done), 32'h0);
    tick();
    check("rej_err_end", 32'(err), 32'h0);
    check("rej_busy2", 32'(busy), 32'h0);

    run_access("rd_poke",  1'b0, 16'h2222, 8'h00, 1'b0, 1'b0, 2, 8'h3C, 1'b1);
    run_access("wr_both",  1'b1, 16'h3333, 8'h99, 1'b1, 1'b1, 1, 8'h00, 1'b0);

    req_wr = 1'b1; addr_in = 16'h5555; wr_data = 8'h11;
    tick();
    req_wr = 1'b0;
    tick();
    check("clr_strobe_low", 32'(mem_wr_n), 32'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_rd = 8'h00;
    check("clr_wr_n",  32'(mem_wr_n), 32'h1);
    check("clr_busy",  32'(busy), 32'h0);
    check("clr_done",  32'(done), 32'h0);
    check("clr_ready", 32'(req_ready), 32'h1);
    check("clr_addr",  32'(mem_addr), 32'h0);
    tick();
    check("clr_done2", 32'(done), 32'h0);
    check("clr_dec_n", 32'(dec_n), 32'h1);
    check("clr_inc_n", 32'(inc_n), 32'h1);
    run_access("rd_after_clr", 1'b0, 16'h0001, 8'h00, 1'b1, 1'b0, 0, 8'hA5, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_access("rnd", 1'($urandom), 16'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), int'($urandom_range(0, 20)), 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
